// File: rtl/pe_pkg.sv
// Shared definitions for the MAC processing element: FSM states, mode
// encodings and saturation bounds derived from the accumulator width.
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  localparam int BOUND_W = 128;

  function automatic logic [BOUND_W-1:0] sat_smax(input int bw);
    return (BOUND_W'(1) << (bw - 1)) - BOUND_W'(1);
  endfunction

  function automatic logic [BOUND_W-1:0] sat_smin(input int bw);
    return BOUND_W'(1) << (bw - 1);
  endfunction

  function automatic logic [BOUND_W-1:0] sat_umax(input int bw);
    return (BOUND_W'(1) << bw) - BOUND_W'(1);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational extend / multiply / accumulate with overflow detection and
// optional clamping; everything is computed in BUS_WIDTH+2 bits.
module mac_sat_add
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int SATURATE   = 1
) (
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0]  acc,
  output logic [BUS_WIDTH-1:0]  sum,
  output logic                  ov
);

  localparam int EW = BUS_WIDTH + 2;
  localparam logic [BUS_WIDTH-1:0] SMAX = BUS_WIDTH'(sat_smax(BUS_WIDTH));
  localparam logic [BUS_WIDTH-1:0] SMIN = BUS_WIDTH'(sat_smin(BUS_WIDTH));
  localparam logic [BUS_WIDTH-1:0] UMAX = BUS_WIDTH'(sat_umax(BUS_WIDTH));

  logic [EW-1:0] a_ext;
  logic [EW-1:0] b_ext;
  logic [EW-1:0] acc_ext;
  logic [EW-1:0] prod;
  logic [EW-1:0] total;

  always_comb begin
    if (signed_mode == MODE_SIGNED) begin
      a_ext   = {{(EW-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
      b_ext   = {{(EW-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
      acc_ext = {{(EW-BUS_WIDTH){acc[BUS_WIDTH-1]}}, acc};
    end else begin
      a_ext   = {{(EW-DATA_WIDTH){1'b0}}, a};
      b_ext   = {{(EW-DATA_WIDTH){1'b0}}, b};
      acc_ext = {{(EW-BUS_WIDTH){1'b0}}, acc};
    end
    // Low EW bits of the product are exact for both encodings.
    prod  = a_ext * b_ext;
    total = acc_ext + prod;
    sum   = total[BUS_WIDTH-1:0];
    ov    = 1'b0;
    if (signed_mode == MODE_SIGNED) begin
      if (total[EW-1:BUS_WIDTH-1] != {(EW-BUS_WIDTH+1){total[EW-1]}}) begin
        ov = 1'b1;
        if (SATURATE != 0) sum = total[EW-1] ? SMIN : SMAX;
      end
    end else if (total[EW-1:BUS_WIDTH] != '0) begin
      ov = 1'b1;
      if (SATURATE != 0) sum = UMAX;
    end
  end

endmodule

// File: rtl/pe_mac_flex.sv
// Systolic PE: forwards A east and B south, accumulates framed operations and
// hands finished sums to a column drain chain that always wins over local loads.
module pe_mac_flex
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int SATURATE   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  signed_mode_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] data_A_i,
  input  logic [DATA_WIDTH-1:0] data_B_i,
  output logic [DATA_WIDTH-1:0] data_A_o,
  output logic [DATA_WIDTH-1:0] data_B_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  shift_i,
  input  logic [BUS_WIDTH-1:0]  shift_data_i,
  input  logic                  shift_valid_i,
  output logic [BUS_WIDTH-1:0]  result_o,
  output logic                  result_valid_o,
  output logic                  result_ov_o,
  output logic                  busy_o,
  output logic                  drop_err_o
);

  state_t               state;
  logic [BUS_WIDTH-1:0] acc;
  logic                 mode;
  logic                 ov;

  logic                 mac_mode;
  logic [BUS_WIDTH-1:0] mac_acc;
  logic [BUS_WIDTH-1:0] mac_sum;
  logic                 mac_ov;

  // The first pair of an operation starts from zero in the mode presented with it.
  assign mac_mode = (state == ST_IDLE) ? signed_mode_i : mode;
  assign mac_acc  = (state == ST_IDLE) ? '0 : acc;
  assign busy_o   = (state == ST_LOAD);

  mac_sat_add #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUS_WIDTH (BUS_WIDTH),
    .SATURATE  (SATURATE)
  ) u_mac (
    .signed_mode(mac_mode),
    .a          (data_A_i),
    .b          (data_B_i),
    .acc        (mac_acc),
    .sum        (mac_sum),
    .ov         (mac_ov)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_A_o <= '0;
      data_B_o <= '0;
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
    end else begin
      data_A_o <= data_A_i;
      data_B_o <= data_B_i;
      valid_o  <= valid_i;
      last_o   <= last_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      acc            <= '0;
      mode           <= MODE_UNSIGNED;
      ov             <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      result_ov_o    <= 1'b0;
      drop_err_o     <= 1'b0;
    end else if (clear_i) begin
      state          <= ST_IDLE;
      acc            <= '0;
      ov             <= 1'b0;
      result_valid_o <= 1'b0;
      result_ov_o    <= 1'b0;
      drop_err_o     <= 1'b0;
    end else begin
      if (shift_i) begin
        result_o       <= shift_data_i;
        result_valid_o <= shift_valid_i;
        result_ov_o    <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            acc   <= mac_sum;
            mode  <= signed_mode_i;
            ov    <= 1'b0;
            state <= last_i ? ST_LOAD : ST_ACC;
          end
        end
        ST_ACC: begin
          if (valid_i) begin
            acc <= mac_sum;
            ov  <= ov | mac_ov;
            if (last_i) state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (valid_i) drop_err_o <= 1'b1;
          if (!shift_i) begin
            result_o       <= acc;
            result_valid_o <= 1'b1;
            result_ov_o    <= ov;
            acc            <= '0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_flex.sv
// Bench for pe_mac_flex: directed scenarios plus randomized operations checked
// against an arithmetic model, on an 8/32 instance and two 7/16 instances.
module tb_pe_mac_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, clear = 1'b0, sgn_mode = 1'b0, valid = 1'b0, last = 1'b0;
  logic        shift = 1'b0, shift_valid = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [31:0] shift_data = '0;
  logic [6:0]  a7 = '0, b7 = '0;
  logic [15:0] sd16 = '0;
  logic        sv16 = 1'b0;

  logic [7:0]  fa8, fb8;
  logic        fv8, fl8, rv8, ov8, busy8, drop8;
  logic [31:0] r8;
  logic [6:0]  fa1, fb1, fa0, fb0;
  logic        fv1, fl1, rv1, ov1, busy1, drop1;
  logic        fv0, fl0, rv0, ov0, busy0, drop0;
  logic [15:0] r1, r0;

  int n_vec = 0;
  int n_err = 0;

  pe_mac_flex #(.DATA_WIDTH(8), .BUS_WIDTH(32), .SATURATE(1)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .signed_mode_i(sgn_mode),
    .valid_i(valid), .last_i(last), .data_A_i(a8), .data_B_i(b8),
    .data_A_o(fa8), .data_B_o(fb8), .valid_o(fv8), .last_o(fl8),
    .shift_i(shift), .shift_data_i(shift_data), .shift_valid_i(shift_valid),
    .result_o(r8), .result_valid_o(rv8), .result_ov_o(ov8),
    .busy_o(busy8), .drop_err_o(drop8));

  pe_mac_flex #(.DATA_WIDTH(7), .BUS_WIDTH(16), .SATURATE(1)) dut_s1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .signed_mode_i(sgn_mode),
    .valid_i(valid), .last_i(last), .data_A_i(a7), .data_B_i(b7),
    .data_A_o(fa1), .data_B_o(fb1), .valid_o(fv1), .last_o(fl1),
    .shift_i(shift), .shift_data_i(sd16), .shift_valid_i(sv16),
    .result_o(r1), .result_valid_o(rv1), .result_ov_o(ov1),
    .busy_o(busy1), .drop_err_o(drop1));

  pe_mac_flex #(.DATA_WIDTH(7), .BUS_WIDTH(16), .SATURATE(0)) dut_s0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .signed_mode_i(sgn_mode),
    .valid_i(valid), .last_i(last), .data_A_i(a7), .data_B_i(b7),
    .data_A_o(fa0), .data_B_o(fb0), .valid_o(fv0), .last_o(fl0),
    .shift_i(shift), .shift_data_i(sd16), .shift_valid_i(sv16),
    .result_o(r0), .result_valid_o(rv0), .result_ov_o(ov0),
    .busy_o(busy0), .drop_err_o(drop0));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Operand value as an integer under the given signedness.
  function automatic longint opval(input longint bits, input int w, input bit sgn);
    longint v;
    v = bits & ((longint'(1) <<< w) - 1);
    if (sgn && v >= (longint'(1) <<< (w - 1))) v -= (longint'(1) <<< w);
    return v;
  endfunction

  // One accumulate step in true integer arithmetic, then clamp or wrap.
  function automatic longint model_mac(input longint acc, input longint a, input longint b,
                                       input bit sgn, input int bw, input bit sat,
                                       output bit ov_step);
    longint s, lo, hi, m;
    m = longint'(1) <<< bw;
    s = acc + a * b;
    if (sgn) begin hi = (m >>> 1) - 1; lo = -(m >>> 1); end
    else     begin hi = m - 1;         lo = 0;          end
    ov_step = (s > hi) || (s < lo);
    if (ov_step) begin
      if (sat) s = (s > hi) ? hi : lo;
      else begin
        s = s & (m - 1);
        if (sgn && s > hi) s -= m;
      end
    end
    return s;
  endfunction

  task automatic test_reset;
    logic [63:0] outs;
    #2;
    outs = {r8, fa8, fb8, fv8, fl8, rv8, ov8, busy8, drop8};
    n_vec++;
    if (outs !== 64'd0) begin n_err++; $display("FAIL reset_main outs=%h want 0", outs); end
    outs = {16'd0, r1, r0, fa1, fb1};
    n_vec++;
    if (outs !== 64'd0) begin n_err++; $display("FAIL reset_small outs=%h want 0", outs); end
    @(negedge clk);
    rst = 1'b0;
    step;
    n_vec++;
    if ({busy8, rv8, busy1, busy0} !== 4'b0) begin
      n_err++; $display("FAIL reset_release busy/rv=%b want 0000", {busy8, rv8, busy1, busy0});
    end
  endtask

  task automatic test_signed;
    sgn_mode = 1'b1; valid = 1'b1; last = 1'b0; a8 = 8'd3; b8 = 8'd4;
    step;
    n_vec++;
    if ({fa8, fb8, fv8, fl8} !== {8'd3, 8'd4, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL fwd_first got %h %h %b %b want 03 04 1 0", fa8, fb8, fv8, fl8);
    end
    a8 = 8'hFE; b8 = 8'd5;
    #1;
    n_vec++;
    if (fa8 !== 8'd3) begin n_err++; $display("FAIL fwd_delay got %h want 03", fa8); end
    step;
    a8 = 8'd7; b8 = 8'hFF; last = 1'b1;
    step;
    n_vec++;
    if ({fa8, fb8, fl8, busy8, rv8} !== {8'd7, 8'hFF, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL load_entry got fa=%h fb=%h last=%b busy=%b rv=%b want 07 ff 1 1 0",
                        fa8, fb8, fl8, busy8, rv8);
    end
    valid = 1'b0; last = 1'b0;
    step;
    n_vec++;
    if ({r8, rv8, ov8, busy8} !== {32'hFFFFFFFB, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL signed_sum got r=%h rv=%b ov=%b busy=%b want fffffffb 1 0 0",
                        r8, rv8, ov8, busy8);
    end
  endtask

  task automatic test_unsigned;
    sgn_mode = 1'b0; valid = 1'b1; a8 = 8'd255; b8 = 8'd255; last = 1'b0;
    step;
    last = 1'b1;
    step;
    valid = 1'b0; last = 1'b0;
    step;
    n_vec++;
    if ({r8, rv8, ov8} !== {32'h0001FC02, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL unsigned_sum got r=%h rv=%b ov=%b want 0001fc02 1 0", r8, rv8, ov8);
    end
  endtask

  task automatic test_saturate;
    sgn_mode = 1'b1; a8 = '0; b8 = '0; a7 = 7'h40; b7 = 7'h40;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; last = (i == 7);
      step;
    end
    valid = 1'b0; last = 1'b0; a7 = '0; b7 = '0;
    step;
    n_vec++;
    if ({r1, ov1, rv1} !== {16'h7FFF, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL sat_clamp got r=%h ov=%b rv=%b want 7fff 1 1", r1, ov1, rv1);
    end
    n_vec++;
    if ({r0, ov0, rv0} !== {16'h8000, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL sat_wrap got r=%h ov=%b rv=%b want 8000 1 1", r0, ov0, rv0);
    end
  endtask

  task automatic test_shift_priority;
    sgn_mode = 1'b1; shift = 1'b1; shift_valid = 1'b1; shift_data = 32'hA5A5A5A5;
    valid = 1'b1; last = 1'b1; a8 = 8'd5; b8 = 8'd6;
    for (int e = 0; e < 3; e++) begin
      step;
      n_vec++;
      if ({r8, rv8, ov8, busy8} !== {32'hA5A5A5A5, 1'b1, 1'b0, 1'b1}) begin
        n_err++; $display("FAIL shift_edge%0d got r=%h rv=%b ov=%b busy=%b want a5a5a5a5 1 0 1",
                          e, r8, rv8, ov8, busy8);
      end
      // A stray pair during LOAD must be dropped and flagged.
      valid = (e == 0); last = 1'b0; a8 = 8'd9; b8 = 8'd9;
    end
    shift = 1'b0; shift_valid = 1'b0; shift_data = '0;
    step;
    n_vec++;
    if ({r8, rv8, busy8, drop8} !== {32'd30, 1'b1, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL shift_release got r=%h rv=%b busy=%b drop=%b want 1e 1 0 1",
                        r8, rv8, busy8, drop8);
    end
  endtask

  task automatic test_clear;
    sgn_mode = 1'b1; valid = 1'b1; last = 1'b0; a8 = 8'd10; b8 = 8'd10;
    step;
    valid = 1'b0; clear = 1'b1;
    step;
    n_vec++;
    if ({r8, rv8, drop8, busy8} !== {32'd30, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL clear_state got r=%h rv=%b drop=%b busy=%b want 1e 0 0 0",
                        r8, rv8, drop8, busy8);
    end
    clear = 1'b0; valid = 1'b1; last = 1'b1; a8 = 8'd2; b8 = 8'd3;
    step;
    valid = 1'b0; last = 1'b0;
    step;
    n_vec++;
    if ({r8, rv8, drop8} !== {32'd6, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL clear_then_op got r=%h rv=%b drop=%b want 6 1 0", r8, rv8, drop8);
    end
  endtask

  task automatic test_async_reset;
    logic [63:0] outs;
    sgn_mode = 1'b1; valid = 1'b1; last = 1'b0; a8 = 8'd4; b8 = 8'd4;
    step;
    #2 rst = 1'b1;
    #1;
    outs = {r8, fa8, fb8, fv8, fl8, rv8, ov8, busy8, drop8};
    n_vec++;
    if (outs !== 64'd0) begin n_err++; $display("FAIL async_reset outs=%h want 0", outs); end
    rst = 1'b0; valid = 1'b1; last = 1'b1; a8 = 8'd1; b8 = 8'd1;
    step;
    valid = 1'b0; last = 1'b0;
    step;
    n_vec++;
    if ({r8, rv8} !== {32'd1, 1'b1}) begin
      n_err++; $display("FAIL after_reset got r=%h rv=%b want 1 1", r8, rv8);
    end
  endtask

  task automatic test_random;
    bit     sgn, t, o8, o1, o0;
    int     n;
    longint e8, e1, e0;
    for (int op = 0; op < 40; op++) begin
      sgn = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      e8 = 0; e1 = 0; e0 = 0; o8 = 0; o1 = 0; o0 = 0;
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) begin
          valid = 1'b0; last = 1'b0; a8 = 8'($urandom); a7 = 7'($urandom);
          step;
        end
        valid = 1'b1; last = (i == n - 1);
        // The mode must only be taken from the first pair.
        sgn_mode = (i == 0) ? sgn : 1'($urandom_range(0, 1));
        a8 = 8'($urandom); b8 = 8'($urandom); a7 = 7'($urandom); b7 = 7'($urandom);
        e8 = model_mac(e8, opval(a8, 8, sgn), opval(b8, 8, sgn), sgn, 32, 1'b1, t); o8 |= t;
        e1 = model_mac(e1, opval(a7, 7, sgn), opval(b7, 7, sgn), sgn, 16, 1'b1, t); o1 |= t;
        e0 = model_mac(e0, opval(a7, 7, sgn), opval(b7, 7, sgn), sgn, 16, 1'b0, t); o0 |= t;
        step;
      end
      valid = 1'b0; last = 1'b0;
      step;
      n_vec++;
      if ({r8, ov8, rv8} !== {e8[31:0], o8, 1'b1}) begin
        n_err++; $display("FAIL rand_w32 op%0d got r=%h ov=%b rv=%b want %h %b 1",
                          op, r8, ov8, rv8, e8[31:0], o8);
      end
      n_vec++;
      if ({r1, ov1, rv1} !== {e1[15:0], o1, 1'b1}) begin
        n_err++; $display("FAIL rand_sat op%0d got r=%h ov=%b rv=%b want %h %b 1",
                          op, r1, ov1, rv1, e1[15:0], o1);
      end
      n_vec++;
      if ({r0, ov0, rv0} !== {e0[15:0], o0, 1'b1}) begin
        n_err++; $display("FAIL rand_wrap op%0d got r=%h ov=%b rv=%b want %h %b 1",
                          op, r0, ov0, rv0, e0[15:0], o0);
      end
    end
    n_vec++;
    if ({drop8, drop1, drop0, fv1, fl1, fv0, fl0, fa0, fb0} !== {7'b0, fa1, fb1}) begin
      n_err++; $display("FAIL small_fwd_drop got %b want drops 0 and matching forwards",
                        {drop8, drop1, drop0, fv1, fl1, fv0, fl0});
    end
  endtask

  initial begin
    test_reset;
    test_signed;
    test_unsigned;
    test_saturate;
    test_shift_priority;
    test_clear;
    test_async_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_mac_flex.md
Name: pe_mac_flex

Overview:
- Next-generation systolic-array processing element: registered forwarding of A/B operands plus a multiply-accumulate (MAC) unit.
- Runtime signed/unsigned mode, optional saturation and explicit operation framing (valid/last).
- A result drain chain shifts finished sums out of a column of PEs, so results leave without a wide parallel bus.
- Sits in the array grid: A flows east, B flows south, results shift south.

Parameters:
- DATA_WIDTH, 8: operand width of A and B.
- BUS_WIDTH, 32: accumulator/result width. Constraint: BUS_WIDTH >= 2*DATA_WIDTH+1.
- SATURATE, 1: 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous clear of MAC state and sticky flags.
- signed_mode_i  in  1  1 = signed operands/result, 0 = unsigned; sampled on first accepted pair.
- valid_i  in  1  data_A_i/data_B_i valid this cycle.
- last_i  in  1  qualifies final pair of an operation (meaningful only with valid_i).
- data_A_i  in  DATA_WIDTH  operand A from west neighbour.
- data_B_i  in  DATA_WIDTH  operand B from north neighbour.
- data_A_o  out  DATA_WIDTH  A forwarded east, 1-cycle delay.
- data_B_o  out  DATA_WIDTH  B forwarded south, 1-cycle delay.
- valid_o  out  1  valid_i delayed 1 cycle.
- last_o  out  1  last_i delayed 1 cycle.
- shift_i  in  1  drain-chain shift enable (common to the column).
- shift_data_i  in  BUS_WIDTH  result from north PE's result_o.
- shift_valid_i  in  1  north PE's result_valid_o.
- result_o  out  BUS_WIDTH  result/drain-chain register.
- result_valid_o  out  1  result_o holds a valid result.
- result_ov_o  out  1  overflow occurred during the operation whose result was last loaded locally.
- busy_o  out  1  high in LOAD state; upstream must not send valid_i.
- drop_err_o  out  1  sticky: a valid pair arrived in LOAD and was dropped.

Behaviour:
- Reset (rst_i high, no clock needed): every output, accumulator, mode register and overflow register = 0; FSM = IDLE.
- Forwarding: data_A_o, data_B_o, valid_o, last_o take their inputs every edge, independent of FSM state, clear_i and shift_i.
- Product:
  - Signed mode: signed DATA_WIDTH x DATA_WIDTH.
  - Unsigned mode: operands zero-extended.
  - Product is extended to BUS_WIDTH+2 bits before the add.
- Overflow detection:
  - Signed mode: sum outside [-2^(BW-1), 2^(BW-1)-1].
  - Unsigned mode: sum > 2^BW-1.
  - On overflow: SATURATE=1 clamps to the nearest bound (signed max/min, unsigned all-ones); SATURATE=0 keeps the low BUS_WIDTH bits.
  - In both cases the internal ov register is set sticky for the operation.
  - Later accumulation continues from the clamped/wrapped value.
- FSM states:
  - IDLE:
    - On valid_i: acc <= product, mode <= signed_mode_i, ov <= 0.
    - Next state ACC, or LOAD if last_i is also high.
  - ACC:
    - On valid_i: acc <= acc + product.
    - If last_i: next state LOAD.
    - Cycles without valid_i are holes; acc is held.
  - LOAD:
    - busy_o=1; acc holds the final sum.
    - If shift_i=0: result_o <= acc, result_valid_o <= 1, result_ov_o <= ov, acc <= 0, next state IDLE.
    - If shift_i=1: wait (the drain has priority).
    - valid_i in LOAD: pair ignored for MAC, drop_err_o <= 1.
- Drain chain:
  - Any edge with shift_i=1: result_o <= shift_data_i, result_valid_o <= shift_valid_i, result_ov_o <= 0.
  - Shift has priority over the local load in all states.
- Latency: last pair sampled at edge k -> result_valid_o high after edge k+1, provided shift_i=0 at edge k+1.
- clear_i (priority below rst_i, above all else):
  - acc=0, ov=0, FSM=IDLE, result_valid_o=0, result_ov_o=0, drop_err_o=0.
  - result_o data is left unchanged.
- rst_i mid-operation: the operation is lost; there is no partial result.

Decomposition:
- Shared package pe_pkg:
  - FSM state encoding (IDLE/ACC/LOAD).
  - Saturation-bound constants as functions of BUS_WIDTH.
  - Mode encodings.
- Sub-module mac_sat_add: combinational extend/multiply/add/overflow/clamp, parameterised by DATA_WIDTH, BUS_WIDTH and SATURATE.
- pe_mac_flex keeps the FSM, forwarding registers and drain chain.

Test Plan:
- Signed 8/32, pairs (3,4),(-2,5),(7,-1) with last on the third, shift_i=0 -> result_o=0xFFFFFFFB, result_valid_o one edge after LOAD entry, result_ov_o=0; data_A_o/data_B_o equal the inputs delayed by 1 cycle.
- Unsigned mode, (255,255) twice -> result_o=0x0001FC02, result_ov_o=0.
- DATA_WIDTH=7, BUS_WIDTH=16, signed, (-64,-64) x8 -> SATURATE=1: result_o=0x7FFF with result_ov_o=1; SATURATE=0: result_o=0x8000 with result_ov_o=1.
- last accepted while shift_i high for 3 edges with shift_data_i=0xA5A5A5A5 and shift_valid_i=1:
  - result_o tracks the chain and busy_o=1 throughout.
  - The local result loads on the first edge with shift_i=0.
  - A valid_i during LOAD -> drop_err_o=1 and the sum is unchanged.
- clear_i pulsed in ACC after pair (10,10), then (2,3) with last -> result_o=6, drop_err_o=0.
- rst_i raised between clock edges in ACC -> all outputs 0 before the next edge; after release, (1,1) with last -> result_o=1.
